// File: rtl/servo_output_pkg.sv
// Shared widths and railed-flag bit positions for the servo output stage.
// Bit positions match the relock block's railed input.
package servo_output_pkg;
  localparam int DATA_W  = 16;
  localparam int SUM_W   = 17;
  localparam int RAIL_HI = 1;
  localparam int RAIL_LO = 0;
endpackage

// File: rtl/servo_output_stage_rail_debounce.sv
// Per-rail debounce: the flag asserts after RAIL_COUNT consecutive clipped samples.
// The flag is registered from the next count, so it drops one cycle after raw clears.
module rail_debounce #(
  parameter int RAIL_COUNT = 16,
  parameter int CNT_W      = 16
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic hold_in,
  input  logic raw_in,
  output logic railed_out
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAIL_COUNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             railed_q, railed_d;

  always_comb begin
    cnt_d    = cnt_q;
    railed_d = railed_q;
    if (!hold_in) begin
      if (!raw_in) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      railed_d = (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cnt_q    <= '0;
      railed_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      railed_q <= railed_d;
    end
  end

  assign railed_out = railed_q;
endmodule

// File: rtl/servo_output_stage.sv
// Servo output stage: sum PID and relock sweep, clamp to limits, slew-limit, drive the DAC.
// Also produces debounced railed flags that feed back to the relock block.
module servo_output_stage
  import servo_output_pkg::*;
#(
  parameter int RAIL_COUNT = 16,
  parameter int CNT_W      = 16
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic signed [15:0] pid_in,
  input  logic signed [15:0] relock_in,
  input  logic               relock_on_in,
  input  logic signed [15:0] min_in,
  input  logic signed [15:0] max_in,
  input  logic        [15:0] slew_in,
  input  logic               hold_in,
  output logic signed [15:0] dac_out,
  output logic        [1:0]  railed_out
);
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic signed [DATA_W-1:0] target_q, target_d;
  logic signed [DATA_W-1:0] dac_q, dac_d;
  logic                     raw_hi_q, raw_hi_d;
  logic                     raw_lo_q, raw_lo_d;

  logic signed [SUM_W-1:0] relock_x, min_x, max_x, clip_hi;
  logic signed [SUM_W-1:0] dac_x, tgt_x, slew_x, delta, step_up, step_dn;

  always_comb begin
    relock_x = relock_on_in ? {relock_in[15], relock_in} : '0;
    sum_d    = {pid_in[15], pid_in} + relock_x;

    max_x    = {max_in[15], max_in};
    min_x    = {min_in[15], min_in};
    raw_hi_d = (sum_q >= max_x);
    raw_lo_d = (sum_q <= min_x);
    // Lower clamp is applied last so a min > max misconfiguration settles at min.
    clip_hi  = raw_hi_d ? max_x : sum_q;
    target_d = (clip_hi <= min_x) ? min_in : clip_hi[DATA_W-1:0];

    dac_x    = {dac_q[15], dac_q};
    tgt_x    = {target_q[15], target_q};
    slew_x   = {1'b0, slew_in};
    delta    = tgt_x - dac_x;
    step_up  = dac_x + slew_x;
    step_dn  = dac_x - slew_x;

    dac_d = dac_q;
    if (!hold_in) begin
      if (slew_in == '0) begin
        dac_d = target_q;
      end else if (delta > slew_x) begin
        dac_d = step_up[DATA_W-1:0];
      end else if (delta < -slew_x) begin
        dac_d = step_dn[DATA_W-1:0];
      end else begin
        dac_d = target_q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sum_q    <= '0;
      target_q <= '0;
      raw_hi_q <= 1'b0;
      raw_lo_q <= 1'b0;
      dac_q    <= '0;
    end else begin
      sum_q    <= sum_d;
      target_q <= target_d;
      raw_hi_q <= raw_hi_d;
      raw_lo_q <= raw_lo_d;
      dac_q    <= dac_d;
    end
  end

  rail_debounce #(.RAIL_COUNT(RAIL_COUNT), .CNT_W(CNT_W)) u_rail_hi (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .hold_in    (hold_in),
    .raw_in     (raw_hi_q),
    .railed_out (railed_out[RAIL_HI])
  );

  rail_debounce #(.RAIL_COUNT(RAIL_COUNT), .CNT_W(CNT_W)) u_rail_lo (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .hold_in    (hold_in),
    .raw_in     (raw_lo_q),
    .railed_out (railed_out[RAIL_LO])
  );

  assign dac_out = dac_q;
endmodule

// File: doc/servo_output_stage.md
Name: servo_output_stage

Overview:
- Downstream neighbour of the relock sweep generator.
- Sums the loop-filter output and the relock sweep, clamps the result to the programmable output limits and applies an optional slew-rate limit.
- Drives the DAC word.
- Generates the debounced two-bit railed flags that feed back into the relock block's railed input.

Parameters:
RAIL_COUNT, 16, consecutive clipped cycles required before a railed flag asserts (1..65535)
CNT_W, 16, width of the per-rail debounce counters; must hold RAIL_COUNT

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst_n_in  input  1  synchronous, active-low reset
pid_in  input  16 signed  loop-filter output
relock_in  input  16 signed  relock sweep output
relock_on_in  input  1  when 1, relock_in is added; when 0, relock_in is ignored
min_in  input  16 signed  lower output limit
max_in  input  16 signed  upper output limit
slew_in  input  16 unsigned  max |change| of dac_out per cycle; 0 = unlimited
hold_in  input  1  freeze output and debounce counters
dac_out  output  16 signed  conditioned output word
railed_out  output  2  [1] = held at upper limit, [0] = held at lower limit

Behaviour:
- Interface: one clock (clk_in). Reset rst_n_in is synchronous and active-low. Reset has priority over every other input.
- Reset values: dac_out = 0, railed_out = 2'b00, both counters = 0, all pipeline registers = 0.
- Stage 1 (registered sum_q, 17 bits signed):
  - sum_q = sext(pid_in) + (relock_on_in ? sext(relock_in) : 0).
  - No overflow is possible at 17 bits.
- Stage 2 (registered):
  - Upper clamp: raw_hi = (sum_q >= sext(max_in)); upper result = max_in.
  - Lower clamp: raw_lo = (sum_q <= sext(min_in)); lower result = min_in.
  - Otherwise target_q = sum_q[15:0].
  - The upper clamp is evaluated first, then the lower clamp.
  - Misconfiguration (min_in > max_in): target_q = min_in; raw_hi and raw_lo may both be 1.
- Stage 3 (dac_out register):
  - slew_in == 0: dac_out <= target_q.
  - slew_in != 0: delta = target_q - dac_out, computed at 17 bits signed.
    - delta > slew_in: dac_out += slew_in.
    - delta < -slew_in: dac_out -= slew_in.
    - Otherwise dac_out <= target_q.
  - Arithmetic is done at 17 bits, so dac_out never wraps.
- Latency: 3 cycles from pid_in/relock_in to dac_out when unlimited. Limits and slew are sampled at stages 2 and 3 respectively.
- Debounce, per rail bit b (hi = 1, lo = 0), each cycle:
  - raw_b registered 1: cnt_b saturating-increments to RAIL_COUNT.
  - raw_b registered 0: cnt_b clears to 0.
  - railed_out[b] = (cnt_b == RAIL_COUNT), registered.
  - Effect: the flag asserts RAIL_COUNT cycles after the first clipped stage-2 sample and deasserts 1 cycle after raw drops.
- Hold (hold_in = 1):
  - Stages 1 and 2 keep updating.
  - dac_out, cnt_hi, cnt_lo and railed_out all freeze.
  - On release, slewing resumes from the frozen dac_out.
- Simultaneous events:
  - rst_n_in = 0 overrides hold_in.
  - If a limit changes while dac_out is outside the new range, dac_out slews toward the new clamped target.
- Reset mid-operation: all state returns to the reset values on the next edge. The pipeline refills in 3 cycles.

Decomposition:
- Shared package servo_output_pkg holds:
  - localparam DATA_W = 16, SUM_W = 17;
  - RAIL_HI = 1, RAIL_LO = 0 bit indices (same encoding as the relock railed input).
- One natural sub-module: rail_debounce. It is instantiated twice and has ports clk_in, rst_n_in, hold_in, raw_in, railed_out, and parameters RAIL_COUNT and CNT_W.

Test Plan:
1. Sum and latency: reset, min = -30000, max = 30000, slew = 0, relock_on = 1, pid = 1000, relock = 234 -> dac_out = 1234 exactly 3 cycles later; railed_out = 00.
2. Upper rail and debounce: pid = 20000, relock = 20000, max = 30000, RAIL_COUNT = 16 -> dac_out = 30000 after 3 cycles. railed_out[1] asserts 16 cycles after the first clipped stage-2 sample. Dropping pid to 0 clears railed_out[1] one cycle after raw clears.
3. Lower rail and extreme sum: pid = -32768, relock = -32768, min = -100 -> dac_out = -100 with no wrap; railed_out[0] asserts after RAIL_COUNT cycles.
4. Slew: dac_out = 0, slew = 100, target step to 1050 -> dac_out steps 100, 200, ... 1000, then 1050, one value per cycle.
5. Hold: hold asserted mid-slew at dac_out = 500 with railed_hi count at 10 -> both stay frozen for 20 cycles. On release, dac_out continues 600, 700, ... and the count resumes from 10.
6. Reset mid-slew and misconfiguration:
   - rst_n_in = 0 for 1 cycle mid-ramp -> dac_out = 0, railed_out = 00, counters 0.
   - min = 500, max = 100 -> dac_out settles at 500.
